mpsoc_msi_wb_master_mux: RTL and testbench
==========================================

Name: mpsoc_msi_wb_master_mux

Overview:
- Downstream consumer of the MSI round-robin arbiter's grant/selection/active outputs. Multiplexes NUM_MASTERS Wishbone classic masters onto one slave port.
- Presents master CYC lines to the arbiter as the request vector.
- Locks onto the selected master for the whole CYC burst and routes ACK/ERR/RTY back to that master only.
- One per slave port in the MSI interconnect.

Parameters:
- NUM_MASTERS, 6, number of master ports; must equal the arbiter's NUM_PORTS.
- AW, 32, address width.
- DW, 32, data width; SEL width is DW/8.
- TIMEOUT, 255, watchdog limit in cycles; used only with the optional feature.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- request_o  out  NUM_MASTERS  to arbiter; equals wbm_cyc_i.
- selection_i  in  $clog2(NUM_MASTERS)  arbiter selection (registered by the arbiter).
- active_i  in  1  arbiter active flag.
- wbm_adr_i  in  NUM_MASTERS*AW  flattened master addresses; master m at [m*AW +: AW].
- wbm_dat_i  in  NUM_MASTERS*DW  master write data.
- wbm_sel_i  in  NUM_MASTERS*DW/8  byte selects.
- wbm_we_i / wbm_cyc_i / wbm_stb_i  in  NUM_MASTERS each  per-master controls.
- wbm_dat_o  out  DW  slave read data, broadcast to all masters.
- wbm_ack_o / wbm_err_o / wbm_rty_o  out  NUM_MASTERS each  per-master terminations.
- wbs_adr_o  out  AW  slave address.
- wbs_dat_o  out  DW  slave write data.
- wbs_sel_o  out  DW/8  slave byte selects.
- wbs_we_o / wbs_cyc_o / wbs_stb_o  out  1 each  slave controls.
- wbs_dat_i  in  DW  slave read data.
- wbs_ack_i / wbs_err_i / wbs_rty_i  in  1 each  slave terminations.
- busy_o  out  1  high in BUSY.

Behaviour:
- Registered state: IDLE/BUSY state, sel register of $clog2(NUM_MASTERS) bits.
- Reset: state=IDLE, sel=0.
  - All wbs_* outputs are combinational from state/sel, so reset forces wbs_cyc_o=wbs_stb_o=wbs_we_o=0, adr/dat/sel=0.
  - wbm_ack_o=wbm_err_o=wbm_rty_o=0, busy_o=0.
- Reset mid-transaction: the transaction is abandoned; no termination is returned to the master.
- IDLE:
  - All wbs_* and wbm terminations are driven 0.
  - On an edge with active_i=1 AND wbm_cyc_i[selection_i]=1: sel<=selection_i, state<=BUSY.
  - The CYC qualification rejects the stale grant the arbiter still presents for one cycle after a master drops CYC.
- BUSY:
  - wbs_{adr,dat,sel,we,cyc,stb}_o = master[sel] fields.
  - wbm_ack_o[sel]=wbs_ack_i, same for err and rty; all other masters' terminations are 0.
  - wbm_dat_o=wbs_dat_i at all times.
- BUSY->IDLE on the edge where wbm_cyc_i[sel]=0. Master changes in active_i or selection_i during BUSY are ignored.
- Latency:
  - Master raises CYC at cycle t; arbiter registers grant at t+1; mux enters BUSY at t+2.
  - wbs_cyc_o is high in cycle t+2.
  - Minimum one IDLE cycle between consecutive grants.
- Simultaneous events: if the slave asserts ack in the same cycle the master drops CYC, the ack is still routed (combinational) and state returns to IDLE.
- Out-of-range selection_i (NUM_MASTERS not a power of 2) is treated as no grant.
- Slave terminations arriving in IDLE are dropped.

Optional Feature:
- Macro MPSOC_MSI_MUX_TIMEOUT_EN.
- With it:
  - A cycle counter clears on IDLE->BUSY and on every wbs_ack_i/err_i/rty_i.
  - It increments each BUSY cycle with wbs_stb_o=1 and no termination.
  - On reaching TIMEOUT, wbm_err_o[sel] pulses 1 for one cycle and wbs_cyc_o/wbs_stb_o are forced 0 in that cycle.
  - State stays BUSY until the master drops CYC; the counter holds at 0 after firing.
- Without it: no counter logic; a hung slave blocks the port indefinitely.

Decomposition:
- Package mpsoc_msi_wb_pkg holds:
  - state enum {IDLE, BUSY};
  - default AW/DW localparams;
  - a function extracting field m from a flattened bus.
- Sub-module mpsoc_msi_wb_watchdog (counter, clear/enable in, expire pulse out), instantiated only under MPSOC_MSI_MUX_TIMEOUT_EN.

Test Plan:
- Reset: rst=1 for 3 cycles with all wbm_cyc_i=6'h3F -> wbs_cyc_o=0, wbm_ack_o=0, busy_o=0 throughout.
- Single master:
  - Stimulus: master 2 CYC/STB, adr=32'h1000, 4-beat burst, slave acks every cycle.
  - Required: wbs_cyc_o rises 2 cycles after CYC; wbs_adr_o=32'h1000; wbm_ack_o=6'b000100 on each beat; IDLE one cycle after CYC drops.
- Contention:
  - Stimulus: masters 0 and 3 raise CYC together; each drops CYC after 1 ack.
  - Required: master 0 served first, then master 3 after exactly one IDLE cycle; master 0 sees no ack while master 3 is served.
- Stale grant:
  - Stimulus: master 1 drops CYC; in the following IDLE cycle active_i=1 with selection_i=1.
  - Required: no re-entry to BUSY; wbs_cyc_o stays 0.
- Reset mid-burst: rst pulsed during beat 2 of a master-4 burst -> wbs_cyc_o=0 on the next cycle; no ack/err reaches master 4.
- Watchdog, with MPSOC_MSI_MUX_TIMEOUT_EN and TIMEOUT=8:
  - Stimulus: slave never acks.
  - Required: wbm_err_o[sel] pulses in BUSY cycle 9; wbs_stb_o=0 in that cycle.
  - Without the macro: no error pulse ever.

Source files
------------

// File: rtl/mpsoc_msi_wb_pkg.sv
// Shared definitions for the MSI Wishbone master multiplexer.
//   state_t     : IDLE / BUSY state encoding of the mux
//   DEF_AW/DW   : default address / data widths
//   bus_field() : extracts field m (width w) from a flattened per-master bus
// Optional feature macro used by the files importing this package:
//   MPSOC_MSI_MUX_TIMEOUT_EN
package mpsoc_msi_wb_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    localparam int unsigned DEF_AW = 32;
    localparam int unsigned DEF_DW = 32;

    // Widest single field and widest flattened bus bus_field() can handle.
    localparam int unsigned MAX_FIELD_W = 64;
    localparam int unsigned MAX_BUS_W   = 2048;

    // Callers zero-extend the flattened bus to MAX_BUS_W and truncate the
    // result back to the field width.
    function automatic logic [MAX_FIELD_W-1:0] bus_field(
        input logic [MAX_BUS_W-1:0] bus,
        input int unsigned          m,
        input int unsigned          w
    );
        logic [MAX_BUS_W-1:0] shifted;
        shifted = bus >> (m * w);
        return shifted[MAX_FIELD_W-1:0] & ({MAX_FIELD_W{1'b1}} >> (MAX_FIELD_W - w));
    endfunction

endpackage

// File: rtl/mpsoc_msi_wb_watchdog.sv
// Bus-hang watchdog for the MSI Wishbone master multiplexer.
//   clk, rst  : clock, synchronous active-high reset
//   clear_i   : restart the count (new grant or any slave termination)
//   enable_i  : count this cycle (strobe outstanding, no termination)
//   expire_o  : one-cycle pulse when the count reaches TIMEOUT
// Only instantiated when MPSOC_MSI_MUX_TIMEOUT_EN is defined.
module mpsoc_msi_wb_watchdog #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clear_i,
    input  logic enable_i,
    output logic expire_o
);

    localparam int unsigned CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] count_q, count_d;
    logic          fired_q, fired_d;

    // fired_q keeps the counter parked at 0 after one pulse so a hung
    // slave produces a single error, not one every TIMEOUT cycles.
    assign expire_o = !fired_q && (count_q == CW'(TIMEOUT));

    always_comb begin
        count_d = count_q;
        fired_d = fired_q;
        if (clear_i) begin
            count_d = '0;
            fired_d = 1'b0;
        end else if (expire_o) begin
            count_d = '0;
            fired_d = 1'b1;
        end else if (enable_i && !fired_q) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
            fired_q <= 1'b0;
        end else begin
            count_q <= count_d;
            fired_q <= fired_d;
        end
    end

endmodule

// File: rtl/mpsoc_msi_wb_master_mux.sv
// Wishbone classic master multiplexer for one MSI slave port.
// Follows the round-robin arbiter's selection, locks onto the chosen master
// for its whole CYC burst and returns ACK/ERR/RTY to that master only.
//   clk, rst          : clock, synchronous active-high reset
//   request_o         : CYC lines presented to the arbiter as requests
//   selection_i       : arbiter selection, active_i : arbiter active flag
//   wbm_*_i / wbm_*_o : flattened master side (master m at [m*W +: W])
//   wbs_*_o / wbs_*_i : single slave side
//   busy_o            : high while a master owns the slave port
// Optional: define MPSOC_MSI_MUX_TIMEOUT_EN to add a watchdog that errors
// out a transaction stalled for TIMEOUT strobed cycles.
module mpsoc_msi_wb_master_mux
    import mpsoc_msi_wb_pkg::*;
#(
    parameter int unsigned NUM_MASTERS = 6,
    parameter int unsigned AW          = DEF_AW,
    parameter int unsigned DW          = DEF_DW,
    parameter int unsigned TIMEOUT     = 255
) (
    input  logic                          clk,
    input  logic                          rst,
    output logic [NUM_MASTERS-1:0]        request_o,
    input  logic [$clog2(NUM_MASTERS)-1:0] selection_i,
    input  logic                          active_i,
    input  logic [NUM_MASTERS*AW-1:0]     wbm_adr_i,
    input  logic [NUM_MASTERS*DW-1:0]     wbm_dat_i,
    input  logic [NUM_MASTERS*DW/8-1:0]   wbm_sel_i,
    input  logic [NUM_MASTERS-1:0]        wbm_we_i,
    input  logic [NUM_MASTERS-1:0]        wbm_cyc_i,
    input  logic [NUM_MASTERS-1:0]        wbm_stb_i,
    output logic [DW-1:0]                 wbm_dat_o,
    output logic [NUM_MASTERS-1:0]        wbm_ack_o,
    output logic [NUM_MASTERS-1:0]        wbm_err_o,
    output logic [NUM_MASTERS-1:0]        wbm_rty_o,
    output logic [AW-1:0]                 wbs_adr_o,
    output logic [DW-1:0]                 wbs_dat_o,
    output logic [DW/8-1:0]               wbs_sel_o,
    output logic                          wbs_we_o,
    output logic                          wbs_cyc_o,
    output logic                          wbs_stb_o,
    input  logic [DW-1:0]                 wbs_dat_i,
    input  logic                          wbs_ack_i,
    input  logic                          wbs_err_i,
    input  logic                          wbs_rty_i,
    output logic                          busy_o
);

    localparam int unsigned SW   = $clog2(NUM_MASTERS);
    localparam int unsigned SELW = DW / 8;

    // Unpack the flattened master buses into per-master arrays.
    logic [MAX_BUS_W-1:0] adr_ext, dat_ext, sel_ext;
    logic [AW-1:0]        adr_arr [NUM_MASTERS];
    logic [DW-1:0]        dat_arr [NUM_MASTERS];
    logic [SELW-1:0]      sel_arr [NUM_MASTERS];

    assign adr_ext = MAX_BUS_W'(wbm_adr_i);
    assign dat_ext = MAX_BUS_W'(wbm_dat_i);
    assign sel_ext = MAX_BUS_W'(wbm_sel_i);

    for (genvar gi = 0; gi < NUM_MASTERS; gi++) begin : g_unpack
        assign adr_arr[gi] = AW'(bus_field(adr_ext, gi, AW));
        assign dat_arr[gi] = DW'(bus_field(dat_ext, gi, DW));
        assign sel_arr[gi] = SELW'(bus_field(sel_ext, gi, SELW));
    end

    state_t        state_q, state_d;
    logic [SW-1:0] sel_q, sel_d;
    logic          grant_hit;
    logic          wd_expire;

    assign request_o = wbm_cyc_i;
    assign wbm_dat_o = wbs_dat_i;
    assign busy_o    = (state_q == BUSY);

    // The CYC qualification rejects the stale grant the arbiter still shows
    // for one cycle after its master released the bus; out-of-range
    // selections (non power-of-two NUM_MASTERS) never grant.
    assign grant_hit = active_i
                    && (32'(selection_i) < NUM_MASTERS)
                    && wbm_cyc_i[selection_i];

`ifdef MPSOC_MSI_MUX_TIMEOUT_EN
    logic wd_clear, wd_enable;

    assign wd_clear  = ((state_q == IDLE) && grant_hit)
                    || ((state_q == BUSY) && (wbs_ack_i || wbs_err_i || wbs_rty_i));
    assign wd_enable = (state_q == BUSY) && wbm_stb_i[sel_q];

    mpsoc_msi_wb_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk      (clk),
        .rst      (rst),
        .clear_i  (wd_clear),
        .enable_i (wd_enable),
        .expire_o (wd_expire)
    );
`else
    assign wd_expire = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        case (state_q)
            IDLE: begin
                if (grant_hit) begin
                    sel_d   = selection_i;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                // Arbiter changes are ignored until the owner drops CYC.
                if (!wbm_cyc_i[sel_q]) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Slave side and terminations are purely a function of state/sel, so
    // terminations arriving in IDLE are dropped and a terminating ack in
    // the cycle the master drops CYC still reaches it.
    always_comb begin
        wbs_adr_o = '0;
        wbs_dat_o = '0;
        wbs_sel_o = '0;
        wbs_we_o  = 1'b0;
        wbs_cyc_o = 1'b0;
        wbs_stb_o = 1'b0;
        wbm_ack_o = '0;
        wbm_err_o = '0;
        wbm_rty_o = '0;
        if (state_q == BUSY) begin
            wbs_adr_o        = adr_arr[sel_q];
            wbs_dat_o        = dat_arr[sel_q];
            wbs_sel_o        = sel_arr[sel_q];
            wbs_we_o         = wbm_we_i[sel_q];
            wbs_cyc_o        = wbm_cyc_i[sel_q] && !wd_expire;
            wbs_stb_o        = wbm_stb_i[sel_q] && !wd_expire;
            wbm_ack_o[sel_q] = wbs_ack_i;
            wbm_err_o[sel_q] = wbs_err_i || wd_expire;
            wbm_rty_o[sel_q] = wbs_rty_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            sel_q   <= '0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
        end
    end

endmodule

// File: tb/tb_mpsoc_msi_wb_master_mux.sv
module tb_mpsoc_msi_wb_master_mux;
    import mpsoc_msi_wb_pkg::*;

    localparam int NM = 6;
    localparam int AW = 32;
    localparam int DW = 32;
`ifdef MPSOC_MSI_MUX_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst;
    logic [NM-1:0]     request_o;
    logic [2:0]        selection_i;
    logic              active_i;
    logic [NM*AW-1:0]  wbm_adr_i;
    logic [NM*DW-1:0]  wbm_dat_i;
    logic [NM*DW/8-1:0] wbm_sel_i;
    logic [NM-1:0]     wbm_we_i, wbm_cyc_i, wbm_stb_i;
    logic [DW-1:0]     wbm_dat_o;
    logic [NM-1:0]     wbm_ack_o, wbm_err_o, wbm_rty_o;
    logic [AW-1:0]     wbs_adr_o;
    logic [DW-1:0]     wbs_dat_o;
    logic [DW/8-1:0]   wbs_sel_o;
    logic              wbs_we_o, wbs_cyc_o, wbs_stb_o;
    logic [DW-1:0]     wbs_dat_i;
    logic              wbs_ack_i, wbs_err_i, wbs_rty_i;
    logic              busy_o;

    always #5 clk = ~clk;

    mpsoc_msi_wb_master_mux #(
        .NUM_MASTERS (NM),
        .AW          (AW),
        .DW          (DW),
        .TIMEOUT     (8)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .request_o   (request_o),
        .selection_i (selection_i),
        .active_i    (active_i),
        .wbm_adr_i   (wbm_adr_i),
        .wbm_dat_i   (wbm_dat_i),
        .wbm_sel_i   (wbm_sel_i),
        .wbm_we_i    (wbm_we_i),
        .wbm_cyc_i   (wbm_cyc_i),
        .wbm_stb_i   (wbm_stb_i),
        .wbm_dat_o   (wbm_dat_o),
        .wbm_ack_o   (wbm_ack_o),
        .wbm_err_o   (wbm_err_o),
        .wbm_rty_o   (wbm_rty_o),
        .wbs_adr_o   (wbs_adr_o),
        .wbs_dat_o   (wbs_dat_o),
        .wbs_sel_o   (wbs_sel_o),
        .wbs_we_o    (wbs_we_o),
        .wbs_cyc_o   (wbs_cyc_o),
        .wbs_stb_o   (wbs_stb_o),
        .wbs_dat_i   (wbs_dat_i),
        .wbs_ack_i   (wbs_ack_i),
        .wbs_err_i   (wbs_err_i),
        .wbs_rty_i   (wbs_rty_i),
        .busy_o      (busy_o)
    );

    // term = {rty, err, ack} driven by the slave in that cycle.
    typedef struct {
        logic        rst;
        logic [5:0]  cyc;
        logic        act;
        logic [2:0]  sel;
        logic [2:0]  term;
        logic        exp_cyc;
        logic [5:0]  exp_ack;
        logic [5:0]  exp_err;
        logic [5:0]  exp_rty;
        logic        exp_busy;
        logic [31:0] exp_adr;
    } vec_t;

    localparam int NV = 31;
    vec_t vecs [NV];

    int pass_cnt = 0;
    int total_cnt = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total_cnt++;
        if (act !== exp)
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        else
            pass_cnt++;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [31:0] a0, a1, a3, a4, m2;
        a0 = 32'hA000_0000; a1 = 32'hA000_0100; a3 = 32'hA000_0300;
        a4 = 32'hA000_0400; m2 = 32'h0000_1000;

        //            rst   cyc     act   sel   term    ecyc  eack   eerr   erty   ebusy eadr
        vecs[0]  = '{1'b1, 6'h3F, 1'b1, 3'd0, 3'b001, 1'b0, 6'h00, 6'h00, 6'h00, 1'b0, 32'h0};
        vecs[1]  = '{1'b1, 6'h3F, 1'b1, 3'd0, 3'b001, 1'b0, 6'h00, 6'h00, 6'h00, 1'b0, 32'h0};
        vecs[2]  = '{1'b1, 6'h3F, 1'b1, 3'd0, 3'b001, 1'b0, 6'h00, 6'h00, 6'h00, 1'b0, 32'h0};
        // master 2 four-beat burst; beats 3/4 terminate with err/rty
        vecs[3]  = '{1'b0, 6'h04, 1'b0, 3'd0, 3'b000, 1'b0, 6'h00, 6'h00, 6'h00, 1'b0, 32'h0};
        vecs[4]  = '{1'b0, 6'h04, 1'b1, 3'd2, 3'b000, 1'b0, 6'h00, 6'h00, 6'h00, 1'b0, 32'h0};
        vecs[5]  = '{1'b0, 6'h04, 1'b1, 3'd2, 3'b001, 1'b1, 6'h04, 6'h00, 6'h00, 1'b1, m2};
        vecs[6]  = '{1'b0, 6'h04, 1'b1, 3'd2, 3'b001, 1'b1, 6'h04, 6'h00, 6'h00, 1'b1, m2};
        vecs[7]  = '{1'b0, 6'h04, 1'b1, 3'd2, 3'b010, 1'b1, 6'h00, 6'h04, 6'h00, 1'b1, m2};
        vecs[8]  = '{1'b0, 6'h04, 1'b1, 3'd2, 3'b100, 1'b1, 6'h00, 6'h00, 6'h04, 1'b1, m2};
        vecs[9]  = '{1'b0, 6'h00, 1'b1, 3'd2, 3'b000, 1'b0, 6'h00, 6'h00, 6'h00, 1'b1, m2};
        vecs[10] = '{1'b0, 6'h00, 1'b1, 3'd2, 3'b000, 1'b0, 6'h00, 6'h00, 6'h00, 1'b0, 32'h0};
        // contention: masters 0 and 3
        vecs[11] = '{1'b0, 6'h09, 1'b0, 3'd0, 3'b000, 1'b0, 6'h00, 6'h00, 6'h00, 1'b0, 32'h0};
        vecs[12] = '{1'b0, 6'h09, 1'b1, 3'd0, 3'b000, 1'b0, 6'h00, 6'h00, 6'h00, 1'b0, 32'h0};
        vecs[13] = '{1'b0, 6'h09, 1'b1, 3'd0, 3'b001, 1'b1, 6'h01, 6'h00, 6'h00, 1'b1, a0};
        vecs[14] = '{1'b0, 6'h08, 1'b1, 3'd0, 3'b000, 1'b0, 6'h00, 6'h00, 6'h00, 1'b1, a0};
        vecs[15] = '{1'b0, 6'h08, 1'b1, 3'd3, 3'b001, 1'b0, 6'h00, 6'h00, 6'h00, 1'b0, 32'h0};
        vecs[16] = '{1'b0, 6'h08, 1'b1, 3'd3, 3'b001, 1'b1, 6'h08, 6'h00, 6'h00, 1'b1, a3};
        vecs[17] = '{1'b0, 6'h00, 1'b1, 3'd3, 3'b001, 1'b0, 6'h08, 6'h00, 6'h00, 1'b1, a3};
        vecs[18] = '{1'b0, 6'h00, 1'b0, 3'd0, 3'b000, 1'b0, 6'h00, 6'h00, 6'h00, 1'b0, 32'h0};
        // stale grant after master 1 releases
        vecs[19] = '{1'b0, 6'h02, 1'b1, 3'd1, 3'b000, 1'b0, 6'h00, 6'h00, 6'h00, 1'b0, 32'h0};
        vecs[20] = '{1'b0, 6'h02, 1'b1, 3'd1, 3'b001, 1'b1, 6'h02, 6'h00, 6'h00, 1'b1, a1};
        vecs[21] = '{1'b0, 6'h00, 1'b1, 3'd1, 3'b000, 1'b0, 6'h00, 6'h00, 6'h00, 1'b1, a1};
        vecs[22] = '{1'b0, 6'h00, 1'b1, 3'd1, 3'b000, 1'b0, 6'h00, 6'h00, 6'h00, 1'b0, 32'h0};
        vecs[23] = '{1'b0, 6'h00, 1'b1, 3'd1, 3'b000, 1'b0, 6'h00, 6'h00, 6'h00, 1'b0, 32'h0};
        // out-of-range selections
        vecs[24] = '{1'b0, 6'h3F, 1'b1, 3'd6, 3'b000, 1'b0, 6'h00, 6'h00, 6'h00, 1'b0, 32'h0};
        vecs[25] = '{1'b0, 6'h3F, 1'b1, 3'd7, 3'b000, 1'b0, 6'h00, 6'h00, 6'h00, 1'b0, 32'h0};
        // reset during beat 2 of a master-4 burst
        vecs[26] = '{1'b0, 6'h10, 1'b1, 3'd4, 3'b000, 1'b0, 6'h00, 6'h00, 6'h00, 1'b0, 32'h0};
        vecs[27] = '{1'b0, 6'h10, 1'b1, 3'd4, 3'b001, 1'b1, 6'h10, 6'h00, 6'h00, 1'b1, a4};
        vecs[28] = '{1'b1, 6'h10, 1'b1, 3'd4, 3'b000, 1'b1, 6'h00, 6'h00, 6'h00, 1'b1, a4};
        vecs[29] = '{1'b0, 6'h10, 1'b0, 3'd4, 3'b001, 1'b0, 6'h00, 6'h00, 6'h00, 1'b0, 32'h0};
        vecs[30] = '{1'b0, 6'h00, 1'b0, 3'd0, 3'b000, 1'b0, 6'h00, 6'h00, 6'h00, 1'b0, 32'h0};

        // Static master fields: master 2 at 0x1000, others 0xA000_0m00.
        for (int m = 0; m < NM; m++) begin
            wbm_adr_i[m*AW +: AW]  = (m == 2) ? 32'h0000_1000 : 32'hA000_0000 + 32'(m) * 32'h100;
            wbm_dat_i[m*DW +: DW]  = 32'hD000_0000 + 32'(m);
            wbm_sel_i[m*4 +: 4]    = 4'(m + 1);
        end
        wbm_we_i    = 6'b101010;
        rst         = 1'b1;
        wbm_cyc_i   = '0;
        wbm_stb_i   = '0;
        active_i    = 1'b0;
        selection_i = '0;
        wbs_dat_i   = '0;
        wbs_ack_i   = 1'b0;
        wbs_err_i   = 1'b0;
        wbs_rty_i   = 1'b0;
        step();

        for (int i = 0; i < NV; i++) begin
            rst         = vecs[i].rst;
            wbm_cyc_i   = vecs[i].cyc;
            wbm_stb_i   = vecs[i].cyc;
            active_i    = vecs[i].act;
            selection_i = vecs[i].sel;
            {wbs_rty_i, wbs_err_i, wbs_ack_i} = vecs[i].term;
            wbs_dat_i   = {16'h5A5A, 16'(i)};
            @(negedge clk);
            $display("vec %0d: cyc_i=%02h sel=%0d act=%0b term=%03b -> wbs_cyc=%0b ack=%02h err=%02h rty=%02h busy=%0b adr=%08h",
                     i, wbm_cyc_i, selection_i, active_i, vecs[i].term,
                     wbs_cyc_o, wbm_ack_o, wbm_err_o, wbm_rty_o, busy_o, wbs_adr_o);
            chk($sformatf("vec%0d wbs_cyc_o", i), 64'(wbs_cyc_o), 64'(vecs[i].exp_cyc));
            chk($sformatf("vec%0d wbm_ack_o", i), 64'(wbm_ack_o), 64'(vecs[i].exp_ack));
            chk($sformatf("vec%0d wbm_err_o", i), 64'(wbm_err_o), 64'(vecs[i].exp_err));
            chk($sformatf("vec%0d wbm_rty_o", i), 64'(wbm_rty_o), 64'(vecs[i].exp_rty));
            chk($sformatf("vec%0d busy_o", i),    64'(busy_o),    64'(vecs[i].exp_busy));
            chk($sformatf("vec%0d wbs_adr_o", i), 64'(wbs_adr_o), 64'(vecs[i].exp_adr));
            chk($sformatf("vec%0d wbm_dat_o", i), 64'(wbm_dat_o), 64'({16'h5A5A, 16'(i)}));
            chk($sformatf("vec%0d request_o", i), 64'(request_o), 64'(vecs[i].cyc));
            step();
        end

        // Hung slave on master 5: watchdog pulse in BUSY cycle 9 if enabled.
        rst = 1'b0;
        {wbs_rty_i, wbs_err_i, wbs_ack_i} = 3'b000;
        wbm_cyc_i   = 6'h20;
        wbm_stb_i   = 6'h20;
        active_i    = 1'b1;
        selection_i = 3'd5;
        @(negedge clk);
        chk("hang entry busy_o", 64'(busy_o), 64'd0);
        step();
        active_i = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            logic fire;
            fire = TO_EN && (k == 9);
            @(negedge clk);
            $display("hang cycle %0d: wbs_cyc=%0b wbs_stb=%0b err=%02h busy=%0b",
                     k, wbs_cyc_o, wbs_stb_o, wbm_err_o, busy_o);
            chk($sformatf("hang%0d wbm_err_o", k), 64'(wbm_err_o), fire ? 64'h20 : 64'h0);
            chk($sformatf("hang%0d wbs_stb_o", k), 64'(wbs_stb_o), 64'(!fire));
            chk($sformatf("hang%0d wbs_cyc_o", k), 64'(wbs_cyc_o), 64'(!fire));
            chk($sformatf("hang%0d busy_o", k),    64'(busy_o),    64'd1);
            if (k == 1) begin
                chk("hang wbs_adr_o", 64'(wbs_adr_o), 64'h0000_0000_A000_0500);
                chk("hang wbs_dat_o", 64'(wbs_dat_o), 64'h0000_0000_D000_0005);
                chk("hang wbs_sel_o", 64'(wbs_sel_o), 64'h6);
                chk("hang wbs_we_o",  64'(wbs_we_o),  64'd1);
            end
            step();
        end
        wbm_cyc_i = 6'h00;
        wbm_stb_i = 6'h00;
        @(negedge clk);
        chk("hang release busy_o", 64'(busy_o), 64'd1);
        step();
        @(negedge clk);
        chk("hang idle busy_o", 64'(busy_o), 64'd0);
        chk("hang idle wbs_cyc_o", 64'(wbs_cyc_o), 64'd0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
